// File: rtl/interrupt_source_controller_pkg.sv
// interrupt_source_controller_pkg: register offsets, claim format and read FSM states
package interrupt_source_controller_pkg;
  localparam logic [7:0] ISC_REG_ENABLE   = 8'h00;
  localparam logic [7:0] ISC_REG_MODE     = 8'h04;
  localparam logic [7:0] ISC_REG_PENDING  = 8'h08;
  localparam logic [7:0] ISC_REG_RAW      = 8'h0C;
  localparam logic [7:0] ISC_REG_CLAIM    = 8'h10;
  localparam logic [7:0] ISC_REG_COMPLETE = 8'h14;
  localparam int ISC_CLAIM_VALID_BIT = 31;
  typedef enum logic {
    ISC_RD_IDLE    = 1'b0,
    ISC_RD_RESPOND = 1'b1
  } isc_rd_state_e;
  // Word-address match; the byte-lane bits of the address are don't-care
  function automatic logic isc_hit(input logic [7:0] addr, input logic [7:0] reg_off);
    return (addr & 8'hFC) == reg_off;
  endfunction
endpackage

// File: rtl/interrupt_priority_encoder.sv
// interrupt_priority_encoder: lowest-index set request and its 5-bit id
module interrupt_priority_encoder #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_id
);
  assign o_valid = |i_req;
  // Scan from the top so the lowest set index is the one left standing
  always_comb begin
    o_id = '0;
    for (int k = N - 1; k >= 0; k--) if (i_req[k]) o_id = 5'(k);
  end
endmodule

// File: rtl/interrupt_source_controller.sv
// interrupt_source_controller: synchronised edge/level sources with claim/complete servicing
module interrupt_source_controller
  import interrupt_source_controller_pkg::*;
#(
  parameter int SOURCE_COUNT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    peripheralEnable,
  input  logic                    peripheralBus_we,
  input  logic                    peripheralBus_oe,
  input  logic [7:0]              peripheralBus_address,
  input  logic [31:0]             peripheralBus_dataWrite,
  output logic [31:0]             peripheralBus_dataRead,
  output logic                    peripheralBus_busy,
  input  logic [SOURCE_COUNT-1:0] irqSources,
  output logic [15:0]             userInterrupts
);
  localparam int N = SOURCE_COUNT;
  logic [SYNC_STAGES-1:0][N-1:0] r_sync;
  logic [N-1:0] r_prev, r_en, r_mode, r_pend, r_insvc;
  logic [15:0] r_irq;
  logic [31:0] r_rdata;
  isc_rd_state_e r_state, w_state_next;
  logic [N-1:0] w_synced, w_edge, w_cand, w_claim_oh, w_done_oh, w_clr, w_pend_next, w_wdata;
  logic w_wr, w_rd, w_valid, w_claim, w_unused;
  logic [4:0] w_id, w_cid;
  logic [31:0] w_rdata_next;

  assign w_synced    = r_sync[SYNC_STAGES-1];
  assign w_edge      = w_synced & ~r_prev;
  assign w_wdata     = peripheralBus_dataWrite[N-1:0];
  assign w_cid       = peripheralBus_dataWrite[4:0];
  assign w_unused    = ^peripheralBus_dataWrite;
  assign w_wr        = peripheralEnable & peripheralBus_we;
  assign w_rd        = rst & peripheralEnable & peripheralBus_oe & ~peripheralBus_we;
  assign w_cand      = r_pend & r_en & ~r_insvc;
  assign w_claim     = w_rd & isc_hit(peripheralBus_address, ISC_REG_CLAIM) & w_valid;
  assign w_claim_oh  = w_claim ? N'(1) << w_id : '0;
  assign w_done_oh   = (w_wr & isc_hit(peripheralBus_address, ISC_REG_COMPLETE) & (32'(w_cid) < N)) ? N'(1) << w_cid : '0;
  assign w_clr       = w_claim_oh | ((w_wr & isc_hit(peripheralBus_address, ISC_REG_PENDING)) ? w_wdata : '0);
  assign w_pend_next = (r_mode & ((r_pend & ~w_clr) | w_edge)) | (~r_mode & w_synced);
  assign w_rdata_next =
    isc_hit(peripheralBus_address, ISC_REG_ENABLE)  ? 32'(r_en) :
    isc_hit(peripheralBus_address, ISC_REG_MODE)    ? 32'(r_mode) :
    isc_hit(peripheralBus_address, ISC_REG_PENDING) ? 32'(r_pend) :
    isc_hit(peripheralBus_address, ISC_REG_RAW)     ? 32'(w_synced) :
    (isc_hit(peripheralBus_address, ISC_REG_CLAIM) & w_valid) ? ((32'(1) << ISC_CLAIM_VALID_BIT) | 32'(w_id)) : '0;
  assign peripheralBus_dataRead = r_rdata;
  assign userInterrupts         = r_irq;

  interrupt_priority_encoder #(.N(N)) u_enc (
    .i_req  (w_cand),
    .o_valid(w_valid),
    .o_id   (w_id)
  );

  // Synchroniser chain and previous-sample flop for edge detection
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= irqSources;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_synced;
    end

  // Enable, mode, pending and in-service state; edge set beats any same-cycle clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_en    <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_insvc <= '0;
    end else begin
      if (w_wr & isc_hit(peripheralBus_address, ISC_REG_ENABLE)) r_en <= w_wdata;
      if (w_wr & isc_hit(peripheralBus_address, ISC_REG_MODE)) r_mode <= w_wdata;
      r_pend  <= w_pend_next;
      r_insvc <= (r_insvc | w_claim_oh) & ~w_done_oh;
    end

  // Read FSM: busy during the request cycle, data valid in the following cycle
  always_comb begin
    w_state_next       = ISC_RD_IDLE;
    peripheralBus_busy = 1'b0;
    case (r_state)
      ISC_RD_IDLE: begin
        peripheralBus_busy = w_rd;
        w_state_next       = w_rd ? ISC_RD_RESPOND : ISC_RD_IDLE;
      end
      default: begin
        peripheralBus_busy = w_rd;
        w_state_next       = w_rd ? ISC_RD_RESPOND : ISC_RD_IDLE;
      end
    endcase
  end

  // Read state register and held read data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= ISC_RD_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_rd) r_rdata <= w_rdata_next;
    end

  // Registered requests to the core
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_irq <= '0;
    else r_irq <= 16'(w_cand);
endmodule

// File: tb/tb_interrupt_source_controller.sv
// tb_interrupt_source_controller: vector table, directed corner cases and random run against a reference model
module tb_interrupt_source_controller;
  localparam int SYNC = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic peripheralEnable = 1'b0, we = 1'b0, oe = 1'b0;
  logic [7:0] address = '0;
  logic [31:0] dataWrite = '0, dataRead;
  logic busy;
  logic [15:0] irqSources = '0, userInterrupts, irq_cur = '0;
  int checks = 0, failures = 0;

  interrupt_source_controller #(.SOURCE_COUNT(16), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .peripheralEnable(peripheralEnable),
    .peripheralBus_we(we), .peripheralBus_oe(oe), .peripheralBus_address(address),
    .peripheralBus_dataWrite(dataWrite), .peripheralBus_dataRead(dataRead),
    .peripheralBus_busy(busy), .irqSources(irqSources), .userInterrupts(userInterrupts)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model state as seen after the latest clock edge
  logic [15:0] m_synced, m_prev, m_pend, m_en, m_mode, m_ins, m_out;
  logic [31:0] m_rdata;
  logic [15:0] hist[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    {m_synced, m_prev, m_pend, m_en, m_mode, m_ins, m_out} = '0;
    m_rdata = '0;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(16'h0);
  endtask

  task automatic model_step();
    logic [15:0] cand, clr, edg, np, en_n, mode_n, ins_n;
    logic [5:0] word;
    logic wr, rd;
    int id;
    cand = m_pend & m_en & ~m_ins;
    id = 0;
    for (int i = 15; i >= 0; i--) if (cand[i]) id = i;
    edg = m_synced & ~m_prev;
    clr = '0;
    en_n = m_en;
    mode_n = m_mode;
    ins_n = m_ins;
    wr = peripheralEnable & we;
    rd = peripheralEnable & oe & ~we;
    word = address[7:2];
    if (wr) begin
      if (word == 0) en_n = dataWrite[15:0];
      else if (word == 1) mode_n = dataWrite[15:0];
      else if (word == 2) clr = dataWrite[15:0];
      else if (word == 5 && dataWrite[4:0] < 16) ins_n[dataWrite[3:0]] = 1'b0;
    end
    if (rd) begin
      m_rdata = word == 0 ? {16'h0, m_en} : word == 1 ? {16'h0, m_mode} :
                word == 2 ? {16'h0, m_pend} : word == 3 ? {16'h0, m_synced} : 32'h0;
      if (word == 4 && cand != 0) begin
        m_rdata = 32'h8000_0000 | 32'(id);
        ins_n[id] = 1'b1;
        clr[id] = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++)
      np[i] = m_mode[i] ? (edg[i] ? 1'b1 : clr[i] ? 1'b0 : m_pend[i]) : m_synced[i];
    m_out = cand;
    m_pend = np;
    m_en = en_n;
    m_mode = mode_n;
    m_ins = ins_n;
    hist.push_front(irqSources);
    m_prev = m_synced;
    m_synced = hist[SYNC-1];
    void'(hist.pop_back());
  endtask

  task automatic cyc(input logic e, input logic w, input logic o, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    peripheralEnable = e; we = w; oe = o; address = a; dataWrite = d; irqSources = irq_cur;
    #1 chk("busy", {31'h0, busy}, {31'h0, e & o & ~w});
    @(posedge clk);
    model_step();
    #1;
    chk("irq_model", {16'h0, userInterrupts}, {16'h0, m_out});
    chk("rdata_model", dataRead, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
    cyc(1'b1, 1'b0, 1'b1, a, 32'h0);
    chk(nm, dataRead, exp);
  endtask

  typedef struct {
    string       nm;
    logic        w;
    logic        o;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  initial begin
    vt.push_back('{"rd_enable0",  1'b0, 1'b1, 8'h00, 32'h0, 32'h0});
    vt.push_back('{"rd_mode0",    1'b0, 1'b1, 8'h04, 32'h0, 32'h0});
    vt.push_back('{"rd_pending0", 1'b0, 1'b1, 8'h08, 32'h0, 32'h0});
    vt.push_back('{"rd_raw0",     1'b0, 1'b1, 8'h0C, 32'h0, 32'h0});
    vt.push_back('{"rd_claim0",   1'b0, 1'b1, 8'h10, 32'h0, 32'h0});
    vt.push_back('{"rd_complete0",1'b0, 1'b1, 8'h14, 32'h0, 32'h0});
    vt.push_back('{"wr_enable",   1'b1, 1'b0, 8'h00, 32'hA5A5_5A5A, 32'h0});
    vt.push_back('{"rd_enable",   1'b0, 1'b1, 8'h00, 32'h0, 32'h0000_5A5A});
    vt.push_back('{"rd_enable_lo",1'b0, 1'b1, 8'h03, 32'h0, 32'h0000_5A5A});
    vt.push_back('{"wr_mode",     1'b1, 1'b0, 8'h04, 32'hFFFF_0F0F, 32'h0});
    vt.push_back('{"rd_mode",     1'b0, 1'b1, 8'h04, 32'h0, 32'h0000_0F0F});
    vt.push_back('{"wr_unmapped", 1'b1, 1'b0, 8'h1C, 32'h1234, 32'h0});
    vt.push_back('{"rd_unmapped", 1'b0, 1'b1, 8'h1C, 32'h0, 32'h0});
    vt.push_back('{"wr_enable_0", 1'b1, 1'b0, 8'h00, 32'h0, 32'h0});
    vt.push_back('{"rd_enable_z", 1'b0, 1'b1, 8'h00, 32'h0, 32'h0});
    vt.push_back('{"wr_mode_0",   1'b1, 1'b0, 8'h04, 32'h0, 32'h0});
    vt.push_back('{"rd_mode_z",   1'b0, 1'b1, 8'h04, 32'h0, 32'h0});

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_irq", {16'h0, userInterrupts}, 32'h0);
    chk("reset_rdata", dataRead, 32'h0);
    rst = 1'b1;

    foreach (vt[i]) begin
      cyc(1'b1, vt[i].w, vt[i].o, vt[i].a, vt[i].d);
      if (vt[i].o) chk(vt[i].nm, dataRead, vt[i].exp);
    end

    // Edge source 3: latency and W1C
    wr(8'h04, 32'h8);
    wr(8'h00, 32'h8);
    irq_cur = 16'h0008;
    idle(1);
    irq_cur = 16'h0;
    idle(2);
    chk("edge3_early", {16'h0, userInterrupts}, 32'h0);
    idle(1);
    chk("edge3_latency", {16'h0, userInterrupts}, 32'h8);
    rd("edge3_pending", 8'h08, 32'h8);
    wr(8'h08, 32'h8);
    idle(1);
    chk("edge3_w1c", {16'h0, userInterrupts}, 32'h0);

    // Edge sources 2 and 5: claim order and complete
    wr(8'h04, 32'h24);
    wr(8'h00, 32'h24);
    irq_cur = 16'h0024;
    idle(1);
    irq_cur = 16'h0;
    idle(4);
    chk("edge25_out", {16'h0, userInterrupts}, 32'h24);
    rd("claim2", 8'h10, 32'h8000_0002);
    idle(1);
    chk("claim2_out", {16'h0, userInterrupts}, 32'h20);
    rd("claim5", 8'h10, 32'h8000_0005);
    idle(1);
    chk("claim5_out", {16'h0, userInterrupts}, 32'h0);
    rd("claim_none", 8'h10, 32'h0);
    wr(8'h14, 32'd2);
    idle(2);
    chk("complete2_out", {16'h0, userInterrupts}, 32'h0);
    wr(8'h14, 32'd5);

    // Level source 7
    wr(8'h04, 32'h0);
    wr(8'h00, 32'h80);
    irq_cur = 16'h0080;
    idle(4);
    chk("level7_out", {16'h0, userInterrupts}, 32'h80);
    rd("claim7", 8'h10, 32'h8000_0007);
    idle(1);
    chk("level7_insvc", {16'h0, userInterrupts}, 32'h0);
    wr(8'h14, 32'd7);
    idle(1);
    chk("level7_reassert", {16'h0, userInterrupts}, 32'h80);
    irq_cur = 16'h0;
    idle(3);
    chk("level7_drop_early", {16'h0, userInterrupts}, 32'h80);
    idle(1);
    chk("level7_drop", {16'h0, userInterrupts}, 32'h0);

    // Source 1: edge and W1C in the same cycle, then out-of-range complete
    wr(8'h04, 32'h2);
    wr(8'h00, 32'h0);
    irq_cur = 16'h0002;
    idle(1);
    irq_cur = 16'h0;
    idle(1);
    wr(8'h08, 32'h2);
    rd("set_beats_w1c", 8'h08, 32'h2);
    wr(8'h14, 32'd20);
    rd("complete20_pend", 8'h08, 32'h2);
    rd("complete20_en", 8'h00, 32'h0);

    // Reset during a read
    wr(8'h00, 32'h2);
    idle(2);
    @(negedge clk);
    peripheralEnable = 1'b1; oe = 1'b1; we = 1'b0; address = 8'h08;
    #1 chk("busy_pre_rst", {31'h0, busy}, 32'h1);
    chk("irq_pre_rst", {16'h0, userInterrupts}, 32'h2);
    #1 rst = 1'b0;
    #1 chk("busy_in_rst", {31'h0, busy}, 32'h0);
    chk("irq_in_rst", {16'h0, userInterrupts}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    peripheralEnable = 1'b0; oe = 1'b0;
    rst = 1'b1;
    model_reset();
    rd("post_rst_enable", 8'h00, 32'h0);
    rd("post_rst_mode", 8'h04, 32'h0);
    rd("post_rst_pending", 8'h08, 32'h0);
    rd("post_rst_raw", 8'h0C, 32'h0);
    rd("post_rst_claim", 8'h10, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] a;
      logic [31:0] d;
      int op;
      if ($urandom % 5 == 0) irq_cur = irq_cur ^ 16'(1 << $urandom_range(0, 15));
      op = int'($urandom % 4);
      a = 8'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      d = (a[7:2] == 6'd5) ? 32'($urandom_range(0, 31)) : $urandom;
      cyc(($urandom % 8) != 0, op[0], op[1], a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interrupt_source_controller.md
Name: interrupt_source_controller

Overview:
- Memory-mapped peripheral that originates the `userInterrupts[15:0]` lines consumed by the core trap unit.
- Synchronises external interrupt inputs and detects edge or level per source.
- Holds the pending, enable and in-service state.
- Gives firmware a claim/complete handshake so that each source is serviced exactly once per event.
- Sits on the peripheral bus next to the other SoC peripherals; its output feeds the core directly.

Parameters:
- SOURCE_COUNT, 16, number of interrupt sources; legal range 1..16. Unused output bits tie to 0.
- SYNC_STAGES, 2, flip-flop stages on each raw input.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- peripheralEnable  input  1  this block is selected.
- peripheralBus_we  input  1  write strobe.
- peripheralBus_oe  input  1  read strobe.
- peripheralBus_address  input  8  byte offset; bits [1:0] are ignored.
- peripheralBus_dataWrite  input  32  write data.
- peripheralBus_dataRead  output  32  read data.
- peripheralBus_busy  output  1  read not yet complete.
- irqSources  input  SOURCE_COUNT  raw asynchronous interrupt inputs.
- userInterrupts  output  16  registered requests to the core trap unit.

Behaviour:
- Reset (rst=0, asynchronous): all of the following clear to 0: sync flops, previous-sample flops, enable, mode, pending, inService, `userInterrupts`, `peripheralBus_dataRead`, `peripheralBus_busy`, read FSM. Release takes effect synchronously on the next clk edge.
- Input path: `synced[i]` is `irqSources[i]` after SYNC_STAGES flops.
  - `prev[i]` holds the previous `synced[i]`.
  - Rising edge event is `synced & ~prev`.
- Register map (word offsets):
  - 0x00 ENABLE RW.
  - 0x04 MODE RW: 1 = rising edge, 0 = level.
  - 0x08 PENDING R/W1C.
  - 0x0C RAW R: returns `synced`.
  - 0x10 CLAIM R.
  - 0x14 COMPLETE W.
  - Other offsets read 0; writes to them are ignored. Bits at or above SOURCE_COUNT read 0 and ignore writes.
- Pending, edge mode: set on an edge event; cleared by a W1C bit or by a claim of that source.
  - If a set and a clear hit the same cycle, set wins.
- Pending, level mode: `pending[i] = synced[i]`; W1C and claim do not affect it.
- Output: `userInterrupts[i]` is registered as `pending[i] & enable[i] & ~inService[i]`.
  - Latency: input edge to output is SYNC_STAGES+2 clk cycles.
- Read handshake, FSM states IDLE and RESPOND:
  - IDLE: when `peripheralEnable & oe` is seen, `busy`=1 in that cycle, capture the address, go to RESPOND.
  - RESPOND: `dataRead` is valid and `busy`=0; return to IDLE.
  - `dataRead` holds its value until the next read.
  - A new oe in the RESPOND cycle is taken as a new read: re-enter RESPOND next cycle with `busy`=1 in the current cycle.
- Writes (`peripheralEnable & we`) complete in one cycle with `busy`=0. We and oe together: the write is performed and the read is ignored.
- CLAIM read, evaluated in the IDLE→RESPOND cycle:
  - Selects the lowest-index i with `pending & enable & ~inService`.
  - Returns `{1'b1, 26'b0, i[4:0]}` and sets `inService[i]`; if edge mode, clears `pending[i]`.
  - If there is no candidate it returns 0 and changes no state.
  - An edge on the claimed source in the same cycle leaves pending=1.
- COMPLETE write: data[4:0] = id.
  - If id < SOURCE_COUNT, clear `inService[id]`.
  - Out-of-range id, or an id not in service: no effect.
  - A COMPLETE and a CLAIM of the same id in the same cycle cannot occur, because a CLAIM is a read.
- Disabling a source (ENABLE bit cleared) drops its output on the next cycle. Pending is retained.
- Reset asserted mid-read: busy drops immediately and the read is abandoned.

Decomposition:
- Shared package holds:
  - the register offset constants (`ISC_REG_ENABLE` … `ISC_REG_COMPLETE`);
  - the CLAIM valid bit position (31);
  - the read FSM state encodings.
- One sub-module, `interrupt_priority_encoder`: combinational, SOURCE_COUNT-wide, produces the lowest-index valid bit and a 5-bit id.

Test Plan:
- Reset, then read every register → all read 0; `userInterrupts`=0x0000; `busy` low after reset release.
- MODE[3]=1, ENABLE[3]=1, pulse `irqSources[3]` for 1 cycle → `userInterrupts`=0x0008 at cycle SYNC_STAGES+2. Read PENDING → 0x0008. W1C 0x0008 → output 0 next cycle.
- Edge sources 2 and 5 pending and enabled:
  - CLAIM → 0x80000002; output becomes 0x0020.
  - CLAIM again → 0x80000005; output becomes 0.
  - CLAIM again → 0x00000000.
  - COMPLETE 2 → inService[2] cleared; output stays 0 because pending[2] is 0.
- Level source 7 (MODE[7]=0, ENABLE[7]=1) held high:
  - CLAIM → 0x80000007.
  - COMPLETE 7 while the input is still high → output reasserts 0x0080.
  - Drop the input → output 0 after SYNC_STAGES+2 cycles.
- Edge event and W1C on source 1 in the same cycle → PENDING[1] remains 1. COMPLETE with id 20 → no state change.
- Pulse rst low while `busy`=1 → `busy` and `userInterrupts` go 0 immediately with no clock edge; all registers read 0 after release.
